dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning number of 64-bit words behind the arbiter.
REQ-002 SHALL have parameter LOCK_MAX, default 16, meaning maximum consecutive locked port-1 grants while port 0 waits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_req / m1_req, input, 1 each, meaning the core LSU (0) or debug/DMA (1) requests access.
REQ-006 SHALL have ports m0_we / m1_we, input, 1 each, meaning the request is a write (1) or a read (0).
REQ-007 SHALL have ports m0_addr / m1_addr, input, 64 each, meaning the byte address.
REQ-008 SHALL have ports m0_wdata / m1_wdata, input, 64 each, meaning the write data.
REQ-009 SHALL have port m1_lock, input, 1, meaning port 1 requests to keep the grant across consecutive cycles.
REQ-010 SHALL have ports m0_gnt / m1_gnt, output, 1 each, meaning the request is accepted this cycle.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid, output, 1 each, meaning a one-cycle response pulse.
REQ-012 SHALL have ports m0_rdata / m1_rdata, output, 64 each, meaning read data, valid with rvalid.
REQ-013 SHALL have ports m0_err / m1_err, output, 1 each, meaning the access faulted, valid with rvalid.
REQ-014 SHALL have ports mem_read / mem_write, output, 1 each, meaning the memory strobes.
REQ-015 SHALL have ports mem_address / mem_write_data, output, 64 each, meaning the memory address and write data.
REQ-016 SHALL have port mem_read_data, input, 64, meaning the memory's asynchronous read data.

Function
REQ-017 SHALL grant at most one port per cycle; gnt is combinational from req and state; a requester holds req, we, addr and wdata stable until gnt.
REQ-018 SHALL, in state IDLE with both requests pending, grant the port not granted most recently (round-robin, 1-bit last pointer); with a single request, grant it.
REQ-019 SHALL drive the mem_* outputs combinationally from the granted port, and drive all of them to 0 when nothing is granted or the access faults.
REQ-020 SHALL flag a fault when addr[2:0]!=0 or addr>=MEM_WORDS*8; a faulting access is granted, issues no memory strobe, and returns err=1 with rdata=0.
REQ-021 SHALL register mem_read_data at the grant edge and pulse the granted port's rvalid for exactly one cycle on the next cycle.
REQ-022 SHALL give read latency = 1 cycle from grant to rvalid.
REQ-023 SHALL complete a write at the grant edge and acknowledge it the next cycle with rvalid=1, rdata=0.
REQ-024 SHALL allow back-to-back grants every cycle, so one response is in flight per port per cycle.
REQ-025 SHALL use the FSM states IDLE and LOCK1:
- IDLE->LOCK1 when port 1 is granted with m1_lock=1.
- In LOCK1, port 1 has absolute priority and a lock counter increments per port-1 grant.
- LOCK1->IDLE when m1_lock=0 or m1_req=0.
- LOCK1->IDLE when the counter reaches LOCK_MAX while m0_req=1; port 0 is then guaranteed the next grant.
REQ-026 SHALL clear the lock counter on entry to IDLE; the counter saturates and never wraps.
REQ-027 SHALL update the round-robin pointer on every grant, including grants made in LOCK1.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronous), force: all rvalid/err=0; all rdata=0; state IDLE; lock counter 0; last pointer=1 (port 0 wins the first tie).
REQ-029 SHALL drop any in-flight response on reset mid-operation and produce no rvalid after release until a new grant.

Structure
REQ-030 SHALL place the state enum, WORD_BYTES=8 and the LOCK_MAX/MEM_WORDS defaults in shared package dmem_arb_pkg.
REQ-031 SHALL implement the two-input round-robin grant logic as sub-module rr_arbiter2; the FSM, fault check and response registers live in dmem_arbiter.

Verification
REQ-032 SHALL cover: memory initialised words 0..2 = 10,20,30; m0 reads 0x8 -> m0_gnt same cycle, next cycle m0_rvalid=1, m0_rdata=20, m0_err=0.
REQ-033 SHALL cover: m0 and m1 both read in the first cycle after reset -> m0 granted first, m1 the next cycle, m1_rdata correct; the tie then alternates.
REQ-034 SHALL cover: m1 writes 0x55 to 0x10, then m0 reads 0x10 -> m0_rdata=0x55; the write ack has rdata=0.
REQ-035 SHALL cover: m0 reads 0x4 and m1 reads 0x2000 -> no mem strobe, err=1, rdata=0 on each response.
REQ-036 SHALL cover: m1_lock held for 20 cycles with m0_req high -> 16 consecutive m1 grants, then one m0 grant, then locking resumes.
REQ-037 SHALL cover: rst_n asserted the cycle after a grant -> no rvalid; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  // Arbiter FSM: plain round-robin, or port 1 holding a locked burst
  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam int unsigned WORD_BYTES    = 8;
  localparam int unsigned LOCK_MAX_DEF  = 16;
  localparam int unsigned MEM_WORDS_DEF = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with priority overrides
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,   // 1: port 1 was granted most recently
  input  logic pri0,   // port 0 wins outright when requesting
  input  logic pri1,   // port 1 wins outright when requesting (below pri0)
  output logic gnt0,
  output logic gnt1
);

  // Overrides first, then alternate on a tie, else grant the lone requester
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (pri0 && req0) begin
      gnt0 = 1'b1;
    end else if (pri1 && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = last;
      gnt1 = !last;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter with port-1 lock and fault check
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned LOCK_MAX  = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [63:0] m0_rdata,
  output logic [63:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) * 64'(WORD_BYTES);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic             m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [63:0]      m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic        pri0, pri1, any_gnt, fault, access_ok, rd_ok;
  logic        sel_we;
  logic [63:0] sel_addr, sel_wdata;

  // Port 1 owns the memory while locked; an exhausted lock hands the next slot to port 0
  assign pri1 = (state_q == LOCK1);
  assign pri0 = (state_q == LOCK1) && (cnt_q >= CNT_MAX);

  rr_arbiter2 u_rr (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_q),
    .pri0 (pri0),
    .pri1 (pri1),
    .gnt0 (m0_gnt),
    .gnt1 (m1_gnt)
  );

  // Route the granted port to memory; faults and idle cycles keep the bus quiet
  always_comb begin
    any_gnt        = m0_gnt | m1_gnt;
    sel_we         = m1_gnt ? m1_we    : m0_we;
    sel_addr       = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata      = m1_gnt ? m1_wdata : m0_wdata;
    fault          = (sel_addr[2:0] != 3'b000) || (sel_addr >= ADDR_LIMIT);
    access_ok      = any_gnt && !fault;
    rd_ok          = access_ok && !sel_we;
    mem_read       = rd_ok;
    mem_write      = access_ok && sel_we;
    mem_address    = access_ok ? sel_addr : 64'd0;
    mem_write_data = (access_ok && sel_we) ? sel_wdata : 64'd0;
  end

  // Next state: lock FSM, saturating lock counter, round-robin pointer, responses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = any_gnt ? m1_gnt : last_q;
    m0_rvalid_d = m0_gnt;
    m1_rvalid_d = m1_gnt;
    m0_err_d    = m0_gnt && fault;
    m1_err_d    = m1_gnt && fault;
    m0_rdata_d  = (m0_gnt && rd_ok) ? mem_read_data : 64'd0;
    m1_rdata_d  = (m1_gnt && rd_ok) ? mem_read_data : 64'd0;
    case (state_q)
      IDLE: begin
        if (m1_gnt && m1_lock) begin
          state_d = LOCK1;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      LOCK1: begin
        if ((pri0 && m0_req) || !m1_lock || !m1_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (m1_gnt && (cnt_q < CNT_MAX)) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state and registered outputs; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= 64'd0;
      m1_rdata_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
